// File: rtl/crc_pkg.sv
// Shared types and named polynomial presets for the streaming CRC blocks.
package crc_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } crc_state_e;

    localparam int unsigned CCITT_W = 16;
    localparam int unsigned CRC32_W = 32;

    localparam logic [CCITT_W-1:0] CCITT_POLY        = 16'h1021;
    localparam logic [CCITT_W-1:0] CCITT_INIT_XMODEM = 16'h0000;
    localparam logic [CCITT_W-1:0] CCITT_INIT_FALSE  = 16'hFFFF;
    localparam logic [CCITT_W-1:0] CCITT_XOROUT      = 16'h0000;
    localparam logic [CCITT_W-1:0] CCITT_RESIDUE     = 16'h0000;

    localparam logic [CRC32_W-1:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [CRC32_W-1:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [CRC32_W-1:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [CRC32_W-1:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc_step.sv
// Combinational advance of a CRC register by one DATA_W-bit beat (serial LFSR, unrolled).
module crc_step #(
    parameter int unsigned      CRC_W  = 16,
    parameter int unsigned      DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
    parameter bit               REFIN  = 1'b0
) (
    input  logic [CRC_W-1:0]  crc,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  nxt
);

    logic [DATA_W-1:0] data_rev;
    logic [DATA_W-1:0] data_ord;
    logic [DATA_W-1:0] d;
    logic [CRC_W-1:0]  r;
    logic              fb;

    for (genvar g = 0; g < DATA_W; g++) begin : g_rev
        assign data_rev[g] = data[DATA_W-1-g];
    end

    // Arrange the beat so that its first-consumed bit sits in the MSB.
    assign data_ord = REFIN ? data_rev : data;

    always_comb begin
        r  = crc;
        d  = data_ord;
        fb = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[CRC_W-1] ^ d[DATA_W-1];
            r  = (r << 1) ^ (fb ? POLY : '0);
            d  = d << 1;
        end
        nxt = r;
    end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: consumes framed beats, presents the frame's CRC and a residue check.
module crc_stream
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 16,
    parameter int unsigned      DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc,
    output logic              m_good
);

    crc_state_e       state_q, state_nx;
    logic [CRC_W-1:0] crc_q, crc_nx;
    logic [CRC_W-1:0] crc_step_c;
    logic [CRC_W-1:0] crc_refl_c;
    logic [CRC_W-1:0] crc_ord_c;
    logic [CRC_W-1:0] m_crc_nx;
    logic             m_good_nx;

    crc_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY),
        .REFIN  (REFIN)
    ) u_step (
        .crc  (crc_q),
        .data (s_data),
        .nxt  (crc_step_c)
    );

    for (genvar g = 0; g < CRC_W; g++) begin : g_refl
        assign crc_refl_c[g] = crc_step_c[CRC_W-1-g];
    end

    // Residue is compared in the result's bit order, matching published CRC catalogue values.
    assign crc_ord_c = REFOUT ? crc_refl_c : crc_step_c;

    always_comb begin
        state_nx  = state_q;
        crc_nx    = crc_q;
        m_crc_nx  = m_crc;
        m_good_nx = m_good;
        if (clear) begin
            state_nx = ST_RUN;
            crc_nx   = INIT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (s_valid) begin
                        if (s_last) begin
                            crc_nx    = INIT;
                            m_crc_nx  = crc_ord_c ^ XOROUT;
                            m_good_nx = (crc_ord_c == RESIDUE);
                            state_nx  = ST_HOLD;
                        end else begin
                            crc_nx = crc_step_c;
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        state_nx = ST_RUN;
                    end
                end
                default: state_nx = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            crc_q   <= INIT;
            m_crc   <= '0;
            m_good  <= 1'b0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else begin
            state_q <= state_nx;
            crc_q   <= crc_nx;
            m_crc   <= m_crc_nx;
            m_good  <= m_good_nx;
            s_ready <= (state_nx == ST_RUN);
            m_valid <= (state_nx == ST_HOLD);
        end
    end

endmodule
